// File: rtl/datapath_types.sv
// Decode->execute bundle and immediate-format selector shared across the datapath.
package datapath_types;

  localparam int DP_XLEN   = 32;
  localparam int DP_REG_AW = 5;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_sel_e;

  typedef struct packed {
    logic                 valid;
    logic [DP_XLEN-1:0]   pc;
    logic [DP_XLEN-1:0]   rs1_data;
    logic [DP_XLEN-1:0]   rs2_data;
    logic [DP_REG_AW-1:0] rs1;
    logic [DP_REG_AW-1:0] rs2;
    logic [DP_REG_AW-1:0] rd;
    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic [6:0]           funct7;
    logic [DP_XLEN-1:0]   imm;
  } decode_exe_t;

endpackage

// File: rtl/rv32i_types.sv
// RV32I base opcode constants shared by every pipeline stage.
package rv32i_types;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

endpackage

// File: rtl/decode_regfile.sv
// Register file with two combinational read ports and one write port; x0 reads as zero.
// With DECODE_WB_BYPASS_EN defined, a same-cycle write is forwarded to the read ports.
module decode_regfile #(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [$clog2(NUM_REGS)-1:0] rs1_addr,
  output logic [XLEN-1:0]             rs1_data,
  input  logic [$clog2(NUM_REGS)-1:0] rs2_addr,
  output logic [XLEN-1:0]             rs2_data,
  input  logic                        wr_en,
  input  logic [$clog2(NUM_REGS)-1:0] wr_addr,
  input  logic [XLEN-1:0]             wr_data
);

  localparam int AW = $clog2(NUM_REGS);

  logic [XLEN-1:0] regs [NUM_REGS];
  logic            wr_fire;

  assign wr_fire = wr_en && (wr_addr != '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_fire) begin
      regs[wr_addr] <= wr_data;
    end
  end

  function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] addr);
    logic [XLEN-1:0] value;
    value = (addr == '0) ? '0 : regs[addr];
`ifdef DECODE_WB_BYPASS_EN
    if (wr_fire && (wr_addr == addr)) value = wr_data;
`endif
    return value;
  endfunction

  assign rs1_data = read_port(rs1_addr);
  assign rs2_data = read_port(rs2_addr);

endmodule

// File: rtl/decode_stage_hs.sv
// Handshaked RV32I decode stage: field decode, immediate select, load-use bubble, registered output.
// Optional feature macro: DECODE_WB_BYPASS_EN (writeback forwarding into captured and held operands).
module decode_stage_hs
  import rv32i_types::*;
  import datapath_types::*;
#(
  parameter int XLEN     = 32,
  parameter int NUM_REGS = 32,
  parameter int REG_AW   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc,
  input  logic [31:0]       in_instr,
  input  logic              flush,
  input  logic              wb_load,
  input  logic [REG_AW-1:0] wb_rd,
  input  logic [XLEN-1:0]   wb_data,
  output logic              out_valid,
  input  logic              exe_ready,
  output logic [XLEN-1:0]   out_pc,
  output logic [XLEN-1:0]   out_rs1_data,
  output logic [XLEN-1:0]   out_rs2_data,
  output logic [REG_AW-1:0] out_rs1,
  output logic [REG_AW-1:0] out_rs2,
  output logic [REG_AW-1:0] out_rd,
  output logic [6:0]        out_opcode,
  output logic [2:0]        out_funct3,
  output logic [6:0]        out_funct7,
  output logic [XLEN-1:0]   out_imm,
  output logic              hazard_stall
);

  decode_exe_t        out_q;
  decode_exe_t        dec_bundle;
  imm_sel_e           imm_sel;
  logic signed [31:0] imm32;
  logic [6:0]         dec_opcode;
  logic [REG_AW-1:0]  dec_rs1;
  logic [REG_AW-1:0]  dec_rs2;
  logic [REG_AW-1:0]  dec_rd;
  logic [XLEN-1:0]    rf_rs1_data;
  logic [XLEN-1:0]    rf_rs2_data;
  logic               uses_rs2;
  logic               hazard;
  logic               accept;

  assign dec_opcode = in_instr[6:0];
  assign dec_rd     = in_instr[7 +: REG_AW];
  assign dec_rs1    = in_instr[15 +: REG_AW];
  assign dec_rs2    = in_instr[20 +: REG_AW];

  decode_regfile #(
    .XLEN     (XLEN),
    .NUM_REGS (NUM_REGS)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .rs1_addr (dec_rs1),
    .rs1_data (rf_rs1_data),
    .rs2_addr (dec_rs2),
    .rs2_data (rf_rs2_data),
    .wr_en    (wb_load),
    .wr_addr  (wb_rd),
    .wr_data  (wb_data)
  );

  assign uses_rs2 = (dec_opcode == OPC_STORE) || (dec_opcode == OPC_BRANCH) ||
                    (dec_opcode == OPC_OP);

  // A held load whose destination feeds the incoming instruction forces one bubble.
  assign hazard = out_q.valid && (out_q.opcode == OPC_LOAD) && (out_q.rd != '0) &&
                  ((out_q.rd == dec_rs1) || (uses_rs2 && (out_q.rd == dec_rs2)));

  assign in_ready     = !rst && !flush && !hazard && (!out_q.valid || exe_ready);
  assign hazard_stall = in_valid && hazard && !flush;
  assign accept       = in_valid && in_ready;

  always_comb begin
    imm_sel = IMM_NONE;
    case (dec_opcode)
      OPC_OP_IMM, OPC_LOAD, OPC_JALR: imm_sel = IMM_I;
      OPC_STORE:                      imm_sel = IMM_S;
      OPC_BRANCH:                     imm_sel = IMM_B;
      OPC_LUI, OPC_AUIPC:             imm_sel = IMM_U;
      OPC_JAL:                        imm_sel = IMM_J;
      default:                        imm_sel = IMM_NONE;
    endcase
  end

  always_comb begin
    imm32 = '0;
    case (imm_sel)
      IMM_I:   imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
      IMM_S:   imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
      IMM_B:   imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7], in_instr[30:25],
                        in_instr[11:8], 1'b0};
      IMM_U:   imm32 = {in_instr[31:12], 12'b0};
      IMM_J:   imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12], in_instr[20],
                        in_instr[30:21], 1'b0};
      default: imm32 = '0;
    endcase
  end

  always_comb begin
    dec_bundle          = '0;
    dec_bundle.valid    = 1'b1;
    dec_bundle.pc       = in_pc;
    dec_bundle.rs1_data = rf_rs1_data;
    dec_bundle.rs2_data = rf_rs2_data;
    dec_bundle.rs1      = dec_rs1;
    dec_bundle.rs2      = dec_rs2;
    dec_bundle.rd       = dec_rd;
    dec_bundle.opcode   = dec_opcode;
    dec_bundle.funct3   = in_instr[14:12];
    dec_bundle.funct7   = in_instr[31:25];
    dec_bundle.imm      = XLEN'(imm32);
  end

  // Flush wins; otherwise capture, drain to an all-zero bubble, or hold while execute stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q <= '0;
    end else if (flush) begin
      out_q <= '0;
    end else if (accept) begin
      out_q <= dec_bundle;
    end else if (!out_q.valid || exe_ready) begin
      out_q <= '0;
    end else begin
`ifdef DECODE_WB_BYPASS_EN
      if (wb_load && (wb_rd != '0)) begin
        if (wb_rd == out_q.rs1) out_q.rs1_data <= wb_data;
        if (wb_rd == out_q.rs2) out_q.rs2_data <= wb_data;
      end
`endif
    end
  end

  assign out_valid    = out_q.valid;
  assign out_pc       = out_q.pc;
  assign out_rs1_data = out_q.rs1_data;
  assign out_rs2_data = out_q.rs2_data;
  assign out_rs1      = out_q.rs1;
  assign out_rs2      = out_q.rs2;
  assign out_rd       = out_q.rd;
  assign out_opcode   = out_q.opcode;
  assign out_funct3   = out_q.funct3;
  assign out_funct7   = out_q.funct7;
  assign out_imm      = out_q.imm;

endmodule

// File: tb/tb_decode_stage_hs.sv
// Directed self-checking bench for decode_stage_hs; expectations follow DECODE_WB_BYPASS_EN if defined.
module tb_decode_stage_hs;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        flush;
  logic        wb_load;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        out_valid;
  logic        exe_ready;
  logic [31:0] out_pc;
  logic [31:0] out_rs1_data;
  logic [31:0] out_rs2_data;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [4:0]  out_rd;
  logic [6:0]  out_opcode;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic [31:0] out_imm;
  logic        hazard_stall;

  int compared   = 0;
  int mismatched = 0;

  localparam logic [31:0] I_ADDI_X1_5   = 32'h00500093;
  localparam logic [31:0] I_ADD_X3_X2   = 32'h002101B3;
  localparam logic [31:0] I_LW_X5       = 32'h0000A283;
  localparam logic [31:0] I_ADD_X6_X5   = 32'h00528333;
  localparam logic [31:0] I_ADDI_X10_7  = 32'h00700513;
  localparam logic [31:0] I_ADDI_X11_M1 = 32'hFFF00593;
  localparam logic [31:0] I_BEQ_M8      = 32'hFE000CE3;
  localparam logic [31:0] I_ADD_X8_X7   = 32'h00038433;
  localparam logic [31:0] I_ADD_X8_X0   = 32'h00000433;

`ifdef DECODE_WB_BYPASS_EN
  localparam logic [31:0] EXP_FWD  = 32'h00001234;
  localparam logic [31:0] EXP_HELD = 32'h00005555;
`else
  localparam logic [31:0] EXP_FWD  = 32'h00000000;
  localparam logic [31:0] EXP_HELD = 32'h00000000;
`endif

  always #5 clk = ~clk;

  decode_stage_hs dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pc        (in_pc),
    .in_instr     (in_instr),
    .flush        (flush),
    .wb_load      (wb_load),
    .wb_rd        (wb_rd),
    .wb_data      (wb_data),
    .out_valid    (out_valid),
    .exe_ready    (exe_ready),
    .out_pc       (out_pc),
    .out_rs1_data (out_rs1_data),
    .out_rs2_data (out_rs2_data),
    .out_rs1      (out_rs1),
    .out_rs2      (out_rs2),
    .out_rd       (out_rd),
    .out_opcode   (out_opcode),
    .out_funct3   (out_funct3),
    .out_funct7   (out_funct7),
    .out_imm      (out_imm),
    .hazard_stall (hazard_stall)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic [31:0] instr);
    in_valid = v;
    in_pc    = pc;
    in_instr = instr;
  endtask

  task automatic setWb(input logic en, input logic [4:0] rd, input logic [31:0] data);
    wb_load = en;
    wb_rd   = rd;
    wb_data = data;
  endtask

  // Advance one edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    flush = 1'b0;
    exe_ready = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0);
    setWb(1'b0, 5'd0, 32'h0);
    tick();
    checkOutput("reset_in_ready", 32'(in_ready), 32'h0);
    checkOutput("reset_out_valid", 32'(out_valid), 32'h0);
    rst = 1'b0;
    #1;
    checkOutput("reset_out_pc", out_pc, 32'h0);
    checkOutput("reset_out_imm", out_imm, 32'h0);

    applyStimulus(1'b1, 32'h100, I_ADDI_X1_5);
    #1;
    checkOutput("addi_in_ready", 32'(in_ready), 32'h1);
    tick();
    checkOutput("addi_valid", 32'(out_valid), 32'h1);
    checkOutput("addi_imm", out_imm, 32'h5);
    checkOutput("addi_rd", 32'(out_rd), 32'h1);
    checkOutput("addi_rs1_data", out_rs1_data, 32'h0);
    checkOutput("addi_pc", out_pc, 32'h100);
    checkOutput("addi_opcode", 32'(out_opcode), 32'h13);

    applyStimulus(1'b0, 32'h0, 32'h0);
    setWb(1'b1, 5'd2, 32'hDEADBEEF);
    tick();
    setWb(1'b0, 5'd0, 32'h0);
    checkOutput("drain_valid", 32'(out_valid), 32'h0);
    applyStimulus(1'b1, 32'h104, I_ADD_X3_X2);
    tick();
    checkOutput("add_rs1_data", out_rs1_data, 32'hDEADBEEF);
    checkOutput("add_rs2_data", out_rs2_data, 32'hDEADBEEF);
    checkOutput("add_rd", 32'(out_rd), 32'h3);

    applyStimulus(1'b1, 32'h108, I_LW_X5);
    tick();
    checkOutput("lw_opcode", 32'(out_opcode), 32'h03);
    checkOutput("lw_funct3", 32'(out_funct3), 32'h2);
    applyStimulus(1'b1, 32'h10C, I_ADD_X6_X5);
    #1;
    checkOutput("lu_hazard_stall", 32'(hazard_stall), 32'h1);
    checkOutput("lu_in_ready", 32'(in_ready), 32'h0);
    tick();
    checkOutput("bubble_valid", 32'(out_valid), 32'h0);
    checkOutput("bubble_opcode", 32'(out_opcode), 32'h0);
    checkOutput("bubble_hazard_clear", 32'(hazard_stall), 32'h0);
    checkOutput("bubble_in_ready", 32'(in_ready), 32'h1);
    tick();
    checkOutput("lu_add_valid", 32'(out_valid), 32'h1);
    checkOutput("lu_add_rs1", 32'(out_rs1), 32'h5);
    checkOutput("lu_add_rd", 32'(out_rd), 32'h6);

    exe_ready = 1'b0;
    applyStimulus(1'b1, 32'h110, I_ADDI_X10_7);
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("stall_in_ready", 32'(in_ready), 32'h0);
      tick();
      checkOutput("stall_valid", 32'(out_valid), 32'h1);
      checkOutput("stall_rd", 32'(out_rd), 32'h6);
      checkOutput("stall_pc", out_pc, 32'h10C);
    end
    exe_ready = 1'b1;
    #1;
    checkOutput("release_in_ready", 32'(in_ready), 32'h1);
    tick();
    checkOutput("release_rd", 32'(out_rd), 32'hA);
    checkOutput("release_imm", out_imm, 32'h7);
    applyStimulus(1'b1, 32'h114, I_ADDI_X11_M1);
    tick();
    checkOutput("next_rd", 32'(out_rd), 32'hB);
    checkOutput("next_imm_neg", out_imm, 32'hFFFFFFFF);

    applyStimulus(1'b1, 32'h200, I_BEQ_M8);
    tick();
    checkOutput("beq_imm", out_imm, 32'hFFFFFFF8);
    checkOutput("beq_opcode", 32'(out_opcode), 32'h63);
    exe_ready = 1'b0;
    flush = 1'b1;
    applyStimulus(1'b1, 32'h204, I_ADDI_X10_7);
    #1;
    checkOutput("flush_in_ready", 32'(in_ready), 32'h0);
    tick();
    flush = 1'b0;
    exe_ready = 1'b1;
    checkOutput("flush_valid", 32'(out_valid), 32'h0);
    checkOutput("flush_pc", out_pc, 32'h0);

    applyStimulus(1'b1, 32'h300, I_LW_X5);
    tick();
    applyStimulus(1'b1, 32'h304, I_ADD_X6_X5);
    flush = 1'b1;
    #1;
    checkOutput("flush_hazard_stall", 32'(hazard_stall), 32'h0);
    checkOutput("flush_hazard_ready", 32'(in_ready), 32'h0);
    tick();
    flush = 1'b0;
    checkOutput("flush_hazard_valid", 32'(out_valid), 32'h0);

    setWb(1'b1, 5'd7, 32'h00001234);
    applyStimulus(1'b1, 32'h400, I_ADD_X8_X7);
    tick();
    setWb(1'b0, 5'd0, 32'h0);
    checkOutput("same_cycle_wb_rs1", out_rs1_data, EXP_FWD);
    exe_ready = 1'b0;
    applyStimulus(1'b0, 32'h0, 32'h0);
    setWb(1'b1, 5'd7, 32'h00005555);
    tick();
    setWb(1'b0, 5'd0, 32'h0);
    checkOutput("held_refresh_rs1", out_rs1_data, EXP_HELD);
    checkOutput("held_refresh_rs2", out_rs2_data, 32'h0);
    checkOutput("held_refresh_valid", 32'(out_valid), 32'h1);
    exe_ready = 1'b1;
    applyStimulus(1'b1, 32'h404, I_ADD_X8_X7);
    tick();
    checkOutput("later_read_rs1", out_rs1_data, 32'h00005555);

    setWb(1'b1, 5'd0, 32'h0000FFFF);
    applyStimulus(1'b1, 32'h408, I_ADD_X8_X0);
    tick();
    setWb(1'b0, 5'd0, 32'h0);
    checkOutput("x0_read_rs1", out_rs1_data, 32'h0);
    checkOutput("x0_read_valid", 32'(out_valid), 32'h1);

    applyStimulus(1'b0, 32'h0, 32'h0);
    exe_ready = 1'b0;
    #3;
    rst = 1'b1;
    #1;
    checkOutput("async_rst_valid", 32'(out_valid), 32'h0);
    checkOutput("async_rst_pc", out_pc, 32'h0);
    checkOutput("async_rst_in_ready", 32'(in_ready), 32'h0);
    tick();
    rst = 1'b0;
    exe_ready = 1'b1;
    applyStimulus(1'b1, 32'h500, I_ADD_X8_X7);
    tick();
    checkOutput("rf_cleared_rs1", out_rs1_data, 32'h0);
    checkOutput("rf_cleared_valid", 32'(out_valid), 32'h1);

    applyStimulus(1'b0, 32'h0, 32'h0);
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/decode_stage_hs.md
# decode_stage_hs

Parametrised, handshaked successor to the single-cycle decode stage. It sits between fetch and execute and holds its own register file. It decodes the RV32I instruction word, selects the immediate per opcode, and reads operands with optional writeback bypass. It also detects load-use hazards and inserts a bubble. A registered decode→execute output stage with valid/ready flow control replaces the previous purely combinational pass-through.

## Interface
Parameters:
- XLEN, default 32: data and PC width.
- NUM_REGS, default 32: register file depth. Must be a power of two; x0 is hardwired to zero.
- REG_AW, default $clog2(NUM_REGS): register index width.

Ports:
- clk, input, 1: single clock. All state updates on the rising edge.
- rst, input, 1: reset. Asynchronous and active-high.
- in_valid, input, 1: fetch presents an instruction.
- in_ready, output, 1: decode accepts it this cycle.
- in_pc, input, XLEN: PC of the incoming instruction.
- in_instr, input, 32: instruction word.
- flush, input, 1: kill the held instruction and drop the input this cycle (branch redirect).
- wb_load, input, 1: writeback enable.
- wb_rd, input, REG_AW: writeback destination.
- wb_data, input, XLEN: writeback data.
- out_valid, output, 1: execute-side bundle valid.
- exe_ready, input, 1: execute accepts the bundle.
- out_pc, output, XLEN: registered PC.
- out_rs1_data, output, XLEN: registered operand A.
- out_rs2_data, output, XLEN: registered operand B.
- out_rs1, out_rs2, out_rd, output, REG_AW each: registered register indices.
- out_opcode, output, 7: registered opcode field.
- out_funct3, output, 3: registered funct3 field.
- out_funct7, output, 7: registered funct7 field.
- out_imm, output, XLEN: sign-extended immediate, selected per opcode.
- hazard_stall, output, 1: a load-use bubble is being inserted this cycle.

## Operation
- Input transfer on in_valid & in_ready. Output transfer on out_valid & exe_ready.
- hazard is asserted when all of the following hold:
  - out_valid;
  - out_opcode == load (0000011);
  - out_rd != 0;
  - out_rd equals in_instr rs1, or in_instr rs2 where the opcode uses rs2 (store, branch, reg-reg).
- in_ready = !flush & !hazard & (!out_valid | exe_ready).
- hazard_stall = in_valid & hazard.
- On a hazard cycle where exe_ready is 1, the output register loads a bubble: out_valid=0 and all fields 0. Next cycle the hazard clears and the instruction is accepted.
- Immediate select:
  - I-type for op-imm, load, jalr;
  - S-type for store;
  - B-type for branch;
  - U-type for lui, auipc;
  - J-type for jal;
  - 0 for any other opcode.
  - Sign extension is to XLEN; B and J immediates have bit 0 = 0.
- Register file: a write occurs when wb_load & wb_rd != 0. Writes to x0 are ignored and reads of x0 return 0.
- Output hold: while out_valid & !exe_ready, all out_* fields hold unchanged, except the operand refresh in Configuration.
- flush dominates everything. Next cycle out_valid=0 and the input is not captured. Register file writes still occur during flush.

## Timing
- Reset values: out_valid=0, and every out_* field and every register entry = 0. in_ready=0 while rst is high.
- Latency is one cycle: an instruction accepted at edge N appears on out_* after edge N.
- Throughput is one instruction per cycle when exe_ready stays high and there is no hazard.
- Load-use costs exactly one bubble cycle.
- Reset asserted mid-operation clears the held instruction immediately (asynchronous). No bubble or flush state survives reset.
- Simultaneous flush and hazard: flush wins and hazard_stall=0.
- Simultaneous wb write and read of the same register: see Configuration.

## Configuration
- DECODE_WB_BYPASS_EN defined:
  - A same-cycle wb write to the register being read (rd != 0) forwards wb_data into the captured operand.
  - Held operands whose index matches a wb write are refreshed with wb_data while stalled.
- DECODE_WB_BYPASS_EN undefined:
  - Register file reads return the pre-write value.
  - Held operands never change.
  - Writeback must therefore be scheduled one cycle earlier by the pipeline.

## Structure
- datapath_types package holds:
  - the decode_exe bundle struct, parametrised via XLEN/REG_AW localparams;
  - the imm_sel enum.
- Opcode constants stay in rv32i_types; no local copies.
- One sub-module, decode_regfile, with parameters XLEN and NUM_REGS:
  - async reset;
  - two combinational read ports;
  - one write port;
  - internal bypass under DECODE_WB_BYPASS_EN.
- Hazard logic, immediate select and the output register stay in decode_stage_hs.

## Test plan
- Reset, then addi x1,x0,5 (0x00500093) with exe_ready=1 -> next cycle:
  - out_valid=1;
  - out_imm=5, out_rd=1, out_rs1_data=0.
- wb x2=0xDEADBEEF, then add x3,x2,x2 -> out_rs1_data = out_rs2_data = 0xDEADBEEF.
- lw x5,0(x1) followed by add x6,x5,x5 -> one cycle with hazard_stall=1 and out_valid=0, then add issues with out_rs1=5.
- exe_ready=0 for 3 cycles with valid held -> out_* stable and in_ready=0; on release, the next instruction follows with no loss.
- flush while holding beq with offset -8 -> out_valid=0 next cycle and in_ready=0 during the flush cycle. Separately, beq with offset -8 decodes to out_imm=0xFFFFFFF8.
- With DECODE_WB_BYPASS_EN, wb x7=0x1234 in the same cycle as decoding add x8,x7,x0 -> out_rs1_data=0x1234. Without the macro -> old value 0.
